// File: rtl/hwpe_stream_streamer_sequencer_if.sv
// Command/flags record types and the handshake bundle joining the sequencer
// to its job source and to the streamer queue controller channels.
package hwpe_stream_streamer_sequencer_pkg;

    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [15:0] trans_size;
        logic [15:0] line_stride;
    } ctrl_sourcesink_t;

    typedef struct packed {
        logic ready_start;
        logic done;
        logic ready_fifo;
    } flags_sourcesink_t;

endpackage

interface hwpe_stream_streamer_sequencer_if
    import hwpe_stream_streamer_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
);
    ctrl_sourcesink_t     job_ctrl;
    logic [CNT_WIDTH-1:0] job_n_cmd;
    logic                 job_valid;
    logic                 job_ready;

    ctrl_sourcesink_t     ctrl;
    logic                 ctrl_valid;
    logic                 ctrl_ready;

    flags_sourcesink_t    flags;
    logic                 flags_valid;
    logic                 flags_ready;

    // The sequencer side: accepts jobs, drives commands, consumes flags.
    modport master (
        input  job_ctrl, job_n_cmd, job_valid, ctrl_ready, flags, flags_valid,
        output job_ready, ctrl, ctrl_valid, flags_ready
    );

    modport slave (
        output job_ctrl, job_n_cmd, job_valid, ctrl_ready, flags, flags_valid,
        input  job_ready, ctrl, ctrl_valid, flags_ready
    );

endinterface

// File: rtl/hwpe_stream_streamer_sequencer.sv
// Issues a job's worth of streamer commands with bounded in-flight credit and
// counts the completions returned on the flags channel.
module hwpe_stream_streamer_sequencer
    import hwpe_stream_streamer_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
)(
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    hwpe_stream_streamer_sequencer_if.master  seq,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [CNT_WIDTH-1:0]              cmd_cnt_o
);

    localparam int unsigned    OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    ctrl_sourcesink_t     ctrl_q;
    logic [CNT_WIDTH-1:0] n_cmd_q;
    logic [CNT_WIDTH-1:0] issued_q;
    logic [CNT_WIDTH-1:0] completed_q;
    logic [OUT_W-1:0]     outstanding_q;

    logic                 job_fire;
    logic                 ctrl_fire;
    logic                 comp_fire;
    logic [CNT_WIDTH-1:0] issued_inc;
    logic [CNT_WIDTH-1:0] completed_nxt;

    assign job_fire      = seq.job_valid & seq.job_ready;
    assign ctrl_fire     = seq.ctrl_valid & seq.ctrl_ready;
    assign comp_fire     = seq.flags_valid & seq.flags_ready & seq.flags.done
                           & (outstanding_q != '0);
    assign issued_inc    = issued_q + 1'b1;
    assign completed_nxt = completed_q + {{(CNT_WIDTH-1){1'b0}}, comp_fire};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else if (clear_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (seq.job_valid)
                       state_d = (seq.job_n_cmd == '0) ? DONE : ISSUE;
            ISSUE: if (ctrl_fire && (issued_inc == n_cmd_q))
                       state_d = DRAIN;
            DRAIN: if (completed_nxt == n_cmd_q)
                       state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valid depends only on registered credit, so a slot freed this cycle is
    // only reused on the following one.
    always_comb begin
        seq.job_ready         = (state_q == IDLE);
        seq.ctrl_valid        = (state_q == ISSUE) && (outstanding_q < MAX_OUT);
        seq.ctrl              = ctrl_q;
        seq.ctrl.req_start    = 1'b1;
        seq.flags_ready       = (state_q == ISSUE) || (state_q == DRAIN);
        busy_o                = (state_q != IDLE);
        done_o                = (state_q == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q        <= '0;
            n_cmd_q       <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            outstanding_q <= '0;
        end else if (clear_i) begin
            ctrl_q        <= '0;
            n_cmd_q       <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            outstanding_q <= '0;
        end else if (job_fire) begin
            ctrl_q        <= seq.job_ctrl;
            n_cmd_q       <= seq.job_n_cmd;
            issued_q      <= '0;
            completed_q   <= '0;
            outstanding_q <= '0;
        end else begin
            if (ctrl_fire)
                issued_q <= issued_inc;
            completed_q <= completed_nxt;
            case ({ctrl_fire, comp_fire})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign cmd_cnt_o = completed_q;

endmodule

// File: tb/tb_hwpe_stream_streamer_sequencer.sv
// Directed bench for the streamer sequencer: job flow, credit gating, clear,
// zero-length jobs and asynchronous reset.
module tb_hwpe_stream_streamer_sequencer;
    import hwpe_stream_streamer_sequencer_pkg::*;

    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          busy;
    logic          done;
    logic [CW-1:0] cmd_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pending[$];
    ctrl_sourcesink_t tmpl;

    hwpe_stream_streamer_sequencer_if #(.CNT_WIDTH(CW)) seq_if ();

    hwpe_stream_streamer_sequencer #(
        .CNT_WIDTH       (CW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (clear),
        .seq       (seq_if),
        .busy_o    (busy),
        .done_o    (done),
        .cmd_cnt_o (cmd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Presents a job for one cycle; returns at the first cycle after acceptance.
    task automatic drive_job(input int n);
        seq_if.job_ctrl  = tmpl;
        seq_if.job_n_cmd = CW'(n);
        seq_if.job_valid = 1'b1;
        #1;
        checks++;
        if (seq_if.job_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL job_ready_accept: got %b expected 1", seq_if.job_ready);
        end
        tick();
        seq_if.job_valid = 1'b0;
    endtask

    // Returns flags for queued completions and logs command transfers.
    task automatic run_responder(input int max_cycles, input int lat,
                                 output int n_xfer, output int n_done, output int n_bad);
        n_xfer = 0;
        n_done = 0;
        n_bad  = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (pending.size() > 0 && pending[0] <= cyc) begin
                seq_if.flags_valid = 1'b1;
                seq_if.flags       = '{ready_start: 1'b1, done: 1'b1, ready_fifo: 1'b1};
            end else begin
                seq_if.flags_valid = 1'b0;
                seq_if.flags       = '0;
            end
            #1;
            if (seq_if.flags_valid && seq_if.flags_ready)
                void'(pending.pop_front());
            if (seq_if.ctrl_valid && seq_if.ctrl_ready) begin
                n_xfer++;
                if (seq_if.ctrl.req_start !== 1'b1 || seq_if.ctrl.base_addr !== tmpl.base_addr
                    || seq_if.ctrl.trans_size !== tmpl.trans_size)
                    n_bad++;
                pending.push_back(cyc + lat);
            end
            if (done)
                n_done++;
            tick();
        end
        seq_if.flags_valid = 1'b0;
        seq_if.flags       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({seq_if.ctrl_valid, seq_if.flags_ready, busy, done, seq_if.job_ready} !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00001",
                     {seq_if.ctrl_valid, seq_if.flags_ready, busy, done, seq_if.job_ready});
        end
        checks++;
        if (cmd_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_cmd_cnt: got %0d expected 0", cmd_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_job();
        int nx, nd, nb;
        seq_if.ctrl_ready = 1'b1;
        drive_job(3);
        run_responder(20, 2, nx, nd, nb);
        checks++;
        if (nx !== 3) begin
            errors++;
            $display("[TB] FAIL basic_xfers: got %0d expected 3", nx);
        end
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("[TB] FAIL basic_cmd_fields: got %0d bad expected 0", nb);
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("[TB] FAIL basic_done_pulses: got %0d expected 1", nd);
        end
        checks++;
        if (cmd_cnt !== 16'd3 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_end: got cnt %0d busy %b expected cnt 3 busy 0", cmd_cnt, busy);
        end
    endtask

    task automatic test_credit();
        int nx, nd, nb;
        nx = 0;
        seq_if.ctrl_ready = 1'b1;
        drive_job(4);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (seq_if.ctrl_valid && seq_if.ctrl_ready)
                nx++;
            tick();
        end
        checks++;
        if (nx !== 2) begin
            errors++;
            $display("[TB] FAIL credit_withheld_xfers: got %0d expected 2", nx);
        end
        seq_if.flags_valid = 1'b1;
        seq_if.flags       = '{ready_start: 1'b1, done: 1'b1, ready_fifo: 1'b1};
        #1;
        checks++;
        if (seq_if.ctrl_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL credit_gate_free_cycle: got %b expected 0", seq_if.ctrl_valid);
        end
        tick();
        seq_if.flags_valid = 1'b0;
        #1;
        checks++;
        if (seq_if.ctrl_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL credit_valid_rise: got %b expected 1", seq_if.ctrl_valid);
        end
        pending = {cyc};
        run_responder(20, 2, nx, nd, nb);
        checks++;
        if (nx !== 2 || nd !== 1 || cmd_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL credit_finish: got xfers %0d done %0d cnt %0d expected 2 1 4", nx, nd, cmd_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int nx, nd, nb;
        seq_if.ctrl_ready = 1'b1;
        drive_job(4);
        tick();
        seq_if.flags_valid = 1'b1;
        seq_if.flags       = '{ready_start: 1'b1, done: 1'b1, ready_fifo: 1'b1};
        tick();
        seq_if.flags_valid = 1'b0;
        #1;
        checks++;
        if (seq_if.ctrl_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_valid_after: got %b expected 1", seq_if.ctrl_valid);
        end
        tick();
        seq_if.flags_valid = 1'b1;
        seq_if.flags       = '{ready_start: 1'b1, done: 1'b0, ready_fifo: 1'b1};
        #1;
        checks++;
        if (seq_if.ctrl_valid !== 1'b0 || seq_if.flags_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_full_credit: got valid %b ready %b expected 0 1",
                     seq_if.ctrl_valid, seq_if.flags_ready);
        end
        tick();
        seq_if.flags_valid = 1'b0;
        seq_if.flags       = '0;
        #1;
        checks++;
        if (cmd_cnt !== 16'd1 || seq_if.ctrl_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done0_ignored: got cnt %0d valid %b expected 1 0", cmd_cnt, seq_if.ctrl_valid);
        end
        pending = {cyc, cyc};
        run_responder(20, 2, nx, nd, nb);
        checks++;
        if (nx !== 1 || nd !== 1 || cmd_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL simul_finish: got xfers %0d done %0d cnt %0d expected 1 1 4", nx, nd, cmd_cnt);
        end
    endtask

    task automatic test_zero_job();
        drive_job(0);
        #1;
        checks++;
        if ({done, busy, seq_if.job_ready, seq_if.ctrl_valid} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL zero_done_cycle: got %b expected 1100",
                     {done, busy, seq_if.job_ready, seq_if.ctrl_valid});
        end
        tick();
        #1;
        checks++;
        if ({done, busy, seq_if.job_ready} !== 3'b001 || cmd_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL zero_after: got %b cnt %0d expected 001 cnt 0",
                     {done, busy, seq_if.job_ready}, cmd_cnt);
        end
    endtask

    task automatic test_clear();
        int nd;
        nd = 0;
        seq_if.ctrl_ready = 1'b1;
        drive_job(2);
        tick();
        tick();
        seq_if.flags_valid = 1'b1;
        seq_if.flags       = '{ready_start: 1'b1, done: 1'b1, ready_fifo: 1'b1};
        tick();
        seq_if.flags_valid = 1'b0;
        #1;
        checks++;
        if (cmd_cnt !== 16'd1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_pre: got cnt %0d busy %b expected 1 1", cmd_cnt, busy);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        checks++;
        if ({busy, done, seq_if.job_ready, seq_if.flags_ready} !== 4'b0010 || cmd_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL clear_post: got %b cnt %0d expected 0010 cnt 0",
                     {busy, done, seq_if.job_ready, seq_if.flags_ready}, cmd_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done)
                nd++;
            tick();
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("[TB] FAIL clear_no_done: got %0d pulses expected 0", nd);
        end
    endtask

    task automatic test_async_reset();
        seq_if.ctrl_ready = 1'b0;
        drive_job(3);
        #1;
        checks++;
        if (seq_if.ctrl_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre: got valid %b busy %b expected 1 1", seq_if.ctrl_valid, busy);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({seq_if.ctrl_valid, busy, seq_if.job_ready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got %b expected 001",
                     {seq_if.ctrl_valid, busy, seq_if.job_ready});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst                = 1'b1;
        clear              = 1'b0;
        tmpl               = '{req_start: 1'b0, base_addr: 32'hCAFE_0100,
                               trans_size: 16'd64, line_stride: 16'd8};
        seq_if.job_ctrl    = '0;
        seq_if.job_n_cmd   = '0;
        seq_if.job_valid   = 1'b0;
        seq_if.ctrl_ready  = 1'b0;
        seq_if.flags       = '0;
        seq_if.flags_valid = 1'b0;
        test_reset();
        test_basic_job();
        test_credit();
        test_simultaneous();
        test_zero_job();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
